// File: rtl/clock_pkg.sv
// Shared types, limits and BCD/12-hour helpers for the alarm clock core.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    SET_TIME  = 2'd1,
    SET_ALARM = 2'd2
  } state_e;

  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [4:0] HRS_MAX = 5'd23;

  function automatic logic [7:0] bin2bcd8(input logic [5:0] v);
    logic [3:0] tens;
    logic [5:0] rem;
    tens = '0;
    rem  = v;
    for (int unsigned i = 0; i < 5; i++) begin
      if (rem >= 6'd10) begin
        rem  = rem - 6'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

  function automatic logic [4:0] to_12h(input logic [4:0] h);
    if (h == 5'd0)
      return 5'd12;
    else if (h > 5'd12)
      return h - 5'd12;
    else
      return h;
  endfunction

  function automatic logic [5:0] inc_mod60(input logic [5:0] v);
    return (v == SEC_MAX) ? '0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc_mod24(input logic [4:0] v);
    return (v == HRS_MAX) ? '0 : v + 5'd1;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level with a one-cycle rising-edge pulse.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;

endmodule

// File: rtl/clock_core_alarm.sv
// hh:mm:ss timekeeping core with 1 Hz prescaler, set modes, 12/24 h display and timed alarm.
module clock_core_alarm
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned ALARM_SECS     = 60,
  parameter int unsigned ALARM_RST_HOUR = 7,
  parameter int unsigned ALARM_RST_MIN  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set,
  input  logic       alarm_set,
  input  logic       hour,
  input  logic       minute,
  input  logic       mode24,
  input  logic       alarm_en,
  output logic [7:0] hours_bcd,
  output logic [7:0] minutes_bcd,
  output logic [7:0] seconds_bcd,
  output logic       ampm,
  output logic       alarm,
  output logic       tick_1hz
);

  localparam int unsigned PRE_W  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned RING_W = (ALARM_SECS > 0) ? $clog2(ALARM_SECS + 1) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(CLK_HZ - 1);
  localparam logic [RING_W-1:0] RING_LOAD  = RING_W'(ALARM_SECS);
  localparam logic [4:0]        AL_HRS_RST = 5'(ALARM_RST_HOUR);
  localparam logic [5:0]        AL_MIN_RST = 6'(ALARM_RST_MIN);
  localparam bit                RING_ON    = (ALARM_SECS != 0);

  logic set_s, alarm_set_s, hour_rise, minute_rise;
  logic hour_lvl_unused, minute_lvl_unused, set_rise_unused, alarm_set_rise_unused;

  sync_edge u_sync_set (
    .clk   (clk),
    .reset (reset),
    .d     (set),
    .level (set_s),
    .rise  (set_rise_unused)
  );

  sync_edge u_sync_alarm_set (
    .clk   (clk),
    .reset (reset),
    .d     (alarm_set),
    .level (alarm_set_s),
    .rise  (alarm_set_rise_unused)
  );

  sync_edge u_sync_hour (
    .clk   (clk),
    .reset (reset),
    .d     (hour),
    .level (hour_lvl_unused),
    .rise  (hour_rise)
  );

  sync_edge u_sync_minute (
    .clk   (clk),
    .reset (reset),
    .d     (minute),
    .level (minute_lvl_unused),
    .rise  (minute_rise)
  );

  state_e             state_q, state_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [5:0]         sec_q, sec_d, min_q, min_d, al_min_q, al_min_d;
  logic [4:0]         hrs_q, hrs_d, al_hrs_q, al_hrs_d;
  logic [RING_W-1:0]  ring_q, ring_d;
  logic               tick, trigger, ring_clear;

  assign tick = (pre_q == PRE_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (set_s)            state_d = SET_TIME;
        else if (alarm_set_s) state_d = SET_ALARM;
      end
      SET_TIME: begin
        if (!set_s) state_d = RUN;
      end
      SET_ALARM: begin
        if (set_s)             state_d = SET_TIME;
        else if (!alarm_set_s) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Time is frozen with the prescaler parked at zero while setting, so the
  // first tick after leaving SET_TIME lands a full second later.
  always_comb begin
    pre_d    = tick ? '0 : pre_q + 1'b1;
    sec_d    = sec_q;
    min_d    = min_q;
    hrs_d    = hrs_q;
    al_hrs_d = al_hrs_q;
    al_min_d = al_min_q;
    if (state_q == SET_TIME) begin
      pre_d = '0;
      sec_d = '0;
      if (hour_rise)   hrs_d = inc_mod24(hrs_q);
      if (minute_rise) min_d = inc_mod60(min_q);
    end else begin
      if (tick) begin
        sec_d = inc_mod60(sec_q);
        if (sec_q == SEC_MAX) begin
          min_d = inc_mod60(min_q);
          if (min_q == MIN_MAX) hrs_d = inc_mod24(hrs_q);
        end
      end
      if (state_q == SET_ALARM) begin
        if (hour_rise)   al_hrs_d = inc_mod24(al_hrs_q);
        if (minute_rise) al_min_d = inc_mod60(al_min_q);
      end
    end
  end

  // Any clear condition wins over a trigger arriving in the same cycle.
  always_comb begin
    trigger    = RING_ON && (state_q == RUN) && tick && alarm_en &&
                 (sec_d == '0) && (min_d == al_min_q) && (hrs_d == al_hrs_q);
    ring_clear = !alarm_en || hour_rise || minute_rise || set_s || alarm_set_s;
    ring_d     = ring_q;
    if (ring_clear)
      ring_d = '0;
    else if (trigger)
      ring_d = RING_LOAD;
    else if (tick && (ring_q != '0))
      ring_d = ring_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q    <= '0;
      sec_q    <= '0;
      min_q    <= '0;
      hrs_q    <= '0;
      al_hrs_q <= AL_HRS_RST;
      al_min_q <= AL_MIN_RST;
      ring_q   <= '0;
    end else begin
      pre_q    <= pre_d;
      sec_q    <= sec_d;
      min_q    <= min_d;
      hrs_q    <= hrs_d;
      al_hrs_q <= al_hrs_d;
      al_min_q <= al_min_d;
      ring_q   <= ring_d;
    end
  end

  logic [4:0] disp_hrs, hrs_shown;
  logic [5:0] disp_min, disp_sec;

  always_comb begin
    disp_hrs  = (state_q == SET_ALARM) ? al_hrs_q : hrs_q;
    disp_min  = (state_q == SET_ALARM) ? al_min_q : min_q;
    disp_sec  = (state_q == SET_ALARM) ? '0 : sec_q;
    hrs_shown = mode24 ? disp_hrs : to_12h(disp_hrs);
  end

  assign hours_bcd   = bin2bcd8({1'b0, hrs_shown});
  assign minutes_bcd = bin2bcd8(disp_min);
  assign seconds_bcd = bin2bcd8(disp_sec);
  assign ampm        = (disp_hrs >= 5'd12);
  assign alarm       = (ring_q != '0);
  assign tick_1hz    = tick;

endmodule

// File: tb/tb_clock_core_alarm.sv
// Directed bench for clock_core_alarm: display-mapping table plus hand-written time/alarm sequences.
module tb_clock_core_alarm;

  logic       clk = 1'b0;
  logic       reset, set, alarm_set, hour, minute, mode24, alarm_en;
  logic [7:0] hours_bcd, minutes_bcd, seconds_bcd;
  logic       ampm, alarm, tick_1hz;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  clock_core_alarm #(
    .CLK_HZ         (4),
    .ALARM_SECS     (3),
    .ALARM_RST_HOUR (7),
    .ALARM_RST_MIN  (0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .set         (set),
    .alarm_set   (alarm_set),
    .hour        (hour),
    .minute      (minute),
    .mode24      (mode24),
    .alarm_en    (alarm_en),
    .hours_bcd   (hours_bcd),
    .minutes_bcd (minutes_bcd),
    .seconds_bcd (seconds_bcd),
    .ampm        (ampm),
    .alarm       (alarm),
    .tick_1hz    (tick_1hz)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         hrs;
    logic [7:0] h12;
    logic [7:0] h24;
    logic       pm;
  } disp_vec_t;

  disp_vec_t vt[6];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns on the negedge after the tick cycle, once the tick has been applied.
  task automatic wait_tick(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!tick_1hz && cyc < 64);
    if (!tick_1hz) begin
      n_vec++;
      n_bad++;
      $display("FAIL tick_timeout: got no tick want tick within 64 cycles");
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic ticks(input int n);
    int c;
    repeat (n) wait_tick(c);
  endtask

  task automatic press_hour(input int n);
    repeat (n) begin
      hour = 1'b1; step(2);
      hour = 1'b0; step(2);
    end
    step(2);
  endtask

  task automatic press_minute(input int n);
    repeat (n) begin
      minute = 1'b1; step(2);
      minute = 1'b0; step(2);
    end
    step(2);
  endtask

  task automatic wait_alarm(input int limit);
    int n = 0;
    while (!alarm && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int cyc;
    int cur;

    vt[0] = '{0,  8'h12, 8'h00, 1'b0};
    vt[1] = '{1,  8'h01, 8'h01, 1'b0};
    vt[2] = '{11, 8'h11, 8'h11, 1'b0};
    vt[3] = '{12, 8'h12, 8'h12, 1'b1};
    vt[4] = '{23, 8'h11, 8'h23, 1'b1};
    vt[5] = '{13, 8'h01, 8'h13, 1'b1};

    reset = 1'b0; set = 1'b0; alarm_set = 1'b0; hour = 1'b0; minute = 1'b0;
    mode24 = 1'b0; alarm_en = 1'b0;

    // Reset values
    #12;
    chk("rst_sec",   seconds_bcd, 8'h00);
    chk("rst_min",   minutes_bcd, 8'h00);
    chk("rst_h12",   hours_bcd,   8'h12);
    chk("rst_ampm",  {7'b0, ampm},     8'h00);
    chk("rst_alarm", {7'b0, alarm},    8'h00);
    chk("rst_tick",  {7'b0, tick_1hz}, 8'h00);
    mode24 = 1'b1; #1;
    chk("rst_h24", hours_bcd, 8'h00);
    mode24 = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Tick spacing and first seconds
    for (int i = 0; i < 4; i++) begin
      wait_tick(cyc);
      chk($sformatf("tick_period_%0d", i), 8'(cyc), 8'd4);
    end
    chk("run_sec4", seconds_bcd, 8'h04);
    chk("run_h12",  hours_bcd,   8'h12);
    chk("run_ampm", {7'b0, ampm}, 8'h00);

    // Set mode: hour display table
    set = 1'b1;
    step(4);
    chk("set_sec0", seconds_bcd, 8'h00);
    cur = 0;
    for (int i = 0; i < 6; i++) begin
      press_hour((vt[i].hrs - cur + 24) % 24);
      cur = vt[i].hrs;
      mode24 = 1'b0; #1;
      chk($sformatf("tbl_h12_%0d", vt[i].hrs), hours_bcd, vt[i].h12);
      chk($sformatf("tbl_pm_%0d", vt[i].hrs), {7'b0, ampm}, {7'b0, vt[i].pm});
      mode24 = 1'b1; #1;
      chk($sformatf("tbl_h24_%0d", vt[i].hrs), hours_bcd, vt[i].h24);
      chk($sformatf("tbl_sec_%0d", vt[i].hrs), seconds_bcd, 8'h00);
    end

    // Minute wraps without carry
    press_minute(61);
    chk("mwrap_min", minutes_bcd, 8'h01);
    chk("mwrap_hrs", hours_bcd,   8'h13);
    set = 1'b0;
    wait_tick(cyc);
    chk("exit_latency", 8'(cyc), 8'd7);
    chk("exit_sec", seconds_bcd, 8'h01);
    chk("exit_hrs", hours_bcd,   8'h13);

    // Full rollover from 23:59:59
    set = 1'b1;
    step(4);
    press_hour(10);
    press_minute(58);
    set = 1'b0;
    ticks(59);
    chk("pre_roll_sec", seconds_bcd, 8'h59);
    chk("pre_roll_min", minutes_bcd, 8'h59);
    chk("pre_roll_h24", hours_bcd,   8'h23);
    mode24 = 1'b0; #1;
    chk("pre_roll_h12", hours_bcd, 8'h11);
    chk("pre_roll_pm",  {7'b0, ampm}, 8'h01);
    wait_tick(cyc);
    chk("roll_sec", seconds_bcd, 8'h00);
    chk("roll_min", minutes_bcd, 8'h00);
    chk("roll_h12", hours_bcd,   8'h12);
    chk("roll_pm",  {7'b0, ampm}, 8'h00);
    mode24 = 1'b1; #1;
    chk("roll_h24", hours_bcd, 8'h00);

    // Program alarm to 00:01
    alarm_set = 1'b1;
    step(4);
    chk("al_show_h", hours_bcd,   8'h07);
    chk("al_show_m", minutes_bcd, 8'h00);
    chk("al_show_s", seconds_bcd, 8'h00);
    press_hour(17);
    press_minute(1);
    chk("al_prog_h", hours_bcd,   8'h00);
    chk("al_prog_m", minutes_bcd, 8'h01);
    chk("al_prog_pm", {7'b0, ampm}, 8'h00);
    alarm_set = 1'b0;
    alarm_en = 1'b1;
    set = 1'b1;
    step(4);
    chk("al_time_m", minutes_bcd, 8'h00);
    chk("al_time_h", hours_bcd,   8'h00);
    set = 1'b0;

    // Ring-out
    ticks(58);
    chk("ring_pre_sec", seconds_bcd, 8'h58);
    chk("ring_pre_al",  {7'b0, alarm}, 8'h00);
    wait_tick(cyc);
    chk("ring_t1_sec", seconds_bcd, 8'h59);
    chk("ring_t1_al",  {7'b0, alarm}, 8'h00);
    wait_tick(cyc);
    chk("ring_t2_min", minutes_bcd, 8'h01);
    chk("ring_t2_al",  {7'b0, alarm}, 8'h01);
    wait_tick(cyc);
    chk("ring_t3_al", {7'b0, alarm}, 8'h01);
    wait_tick(cyc);
    chk("ring_t4_al", {7'b0, alarm}, 8'h01);
    wait_tick(cyc);
    chk("ring_t5_al",  {7'b0, alarm}, 8'h00);
    chk("ring_t5_sec", seconds_bcd, 8'h03);

    // Acknowledge with a minute press
    alarm_set = 1'b1;
    step(4);
    press_minute(1);
    alarm_set = 1'b0;
    step(4);
    wait_alarm(400);
    chk("ack_ringing", {7'b0, alarm}, 8'h01);
    chk("ack_min",     minutes_bcd, 8'h02);
    chk("ack_sec",     seconds_bcd, 8'h00);
    minute = 1'b1;
    for (int i = 0; i < 4 && alarm; i++) @(negedge clk);
    chk("ack_cleared", {7'b0, alarm}, 8'h00);
    minute = 1'b0;
    step(4);
    chk("ack_time_kept", minutes_bcd, 8'h02);

    // Reset while entering set mode with the alarm ringing
    alarm_set = 1'b1;
    step(4);
    press_minute(1);
    alarm_set = 1'b0;
    step(4);
    wait_alarm(400);
    chk("mid_ringing", {7'b0, alarm}, 8'h01);
    set = 1'b1;
    @(negedge clk);
    chk("mid_still_ringing", {7'b0, alarm}, 8'h01);
    #2 reset = 1'b0;
    #1;
    chk("mid_alarm", {7'b0, alarm},    8'h00);
    chk("mid_tick",  {7'b0, tick_1hz}, 8'h00);
    chk("mid_sec",   seconds_bcd, 8'h00);
    chk("mid_min",   minutes_bcd, 8'h00);
    chk("mid_hrs",   hours_bcd,   8'h00);
    set = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    wait_tick(cyc);
    chk("post_rst_period", 8'(cyc), 8'd4);
    chk("post_rst_sec", seconds_bcd, 8'h01);
    alarm_set = 1'b1;
    step(4);
    chk("post_rst_al_h", hours_bcd,   8'h07);
    chk("post_rst_al_m", minutes_bcd, 8'h00);
    chk("post_rst_al_s", seconds_bcd, 8'h00);
    alarm_set = 1'b0;
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
